// File: rtl/tlk2711_tx_framer.sv
// Transmit framer for the TLK2711-B parallel TX bus.
// Wraps each fabric packet as SOF, sequence header, payload, checksum, EOF and
// keeps the link filled with K28.5 idle words between and inside frames.
//
// Ports:
//   i_clk, i_rst            TX word clock, asynchronous active-high reset
//   i_tdata/i_tvalid/i_tlast/o_tready   16-bit payload stream (AXI-Stream style)
//   i_loopen, i_prbsen      loopback / PRBS requests (registered to the device pins)
//   o_txd, o_tkmsb, o_tklsb TLK2711 transmit data and K-char flags (registered)
//   o_tlk_enable, o_tlk_lckrefn, o_tlk_loopen, o_tlk_prbsen   device control pins
//   o_seq                   sequence number carried by the next frame header
//   o_busy                  high from the SOF word through the EOF word
//   o_err_oversize          one-cycle pulse, aligned with EOF, when a frame was truncated
module tlk2711_tx_framer #(
    parameter int unsigned MAX_LEN   = 1024,
    parameter int unsigned IFG_WORDS = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_tdata,
    input  logic        i_tvalid,
    input  logic        i_tlast,
    output logic        o_tready,
    input  logic        i_loopen,
    input  logic        i_prbsen,
    output logic [15:0] o_txd,
    output logic        o_tkmsb,
    output logic        o_tklsb,
    output logic        o_tlk_enable,
    output logic        o_tlk_lckrefn,
    output logic        o_tlk_loopen,
    output logic        o_tlk_prbsen,
    output logic [15:0] o_seq,
    output logic        o_busy,
    output logic        o_err_oversize
);

    localparam int unsigned WORD_W = 16;
    localparam int unsigned CNT_W  = 17;
    localparam int unsigned GAP_W  = 9;

    localparam logic [WORD_W-1:0] K_IDLE = 16'hC5BC;
    localparam logic [WORD_W-1:0] K_SOF  = 16'h50FB;
    localparam logic [WORD_W-1:0] K_EOF  = 16'h50FD;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOF,
        ST_HDR,
        ST_PAY,
        ST_CHK,
        ST_EOF,
        ST_DROP,
        ST_GAP
    } state_t;

    // With no inter-frame gap configured a finished frame returns straight to IDLE.
    localparam state_t ST_AFTER = (IFG_WORDS == 0) ? ST_IDLE : ST_GAP;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WORD_W-1:0]  csum;
    logic               oversize;
    logic [GAP_W-1:0]   gap_cnt;

    logic               accept;
    logic               hit_max;
    logic               last_gap;

    logic [WORD_W-1:0]  txd_d;
    logic               tklsb_d;
    logic               busy_d;
    logic               err_d;

    // Ready depends on state only, so the fabric never sees a ready->valid loop.
    assign o_tready = ((state == ST_PAY) && (cnt < CNT_W'(MAX_LEN))) || (state == ST_DROP);
    assign accept   = i_tvalid & o_tready;
    assign hit_max  = (cnt + CNT_W'(1)) == CNT_W'(MAX_LEN);
    assign last_gap = (gap_cnt + GAP_W'(1)) == GAP_W'(IFG_WORDS);

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (i_tvalid) state_nxt = ST_SOF;
            ST_SOF:  state_nxt = ST_HDR;
            ST_HDR:  state_nxt = ST_PAY;
            ST_PAY:  if (accept && (i_tlast || hit_max)) state_nxt = ST_CHK;
            ST_CHK:  state_nxt = ST_EOF;
            ST_EOF:  state_nxt = oversize ? ST_DROP : ST_AFTER;
            ST_DROP: if (accept && i_tlast) state_nxt = ST_AFTER;
            ST_GAP:  if (last_gap) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: word to launch on the TX bus at the next clock edge.
    always_comb begin
        txd_d   = K_IDLE;
        tklsb_d = 1'b1;
        busy_d  = 1'b0;
        err_d   = 1'b0;
        case (state)
            ST_SOF: begin
                txd_d  = K_SOF;
                busy_d = 1'b1;
            end
            ST_HDR: begin
                txd_d   = o_seq;
                tklsb_d = 1'b0;
                busy_d  = 1'b1;
            end
            ST_PAY: begin
                busy_d = 1'b1;
                // Without a valid word the link is kept alive with idle fill.
                if (accept) begin
                    txd_d   = i_tdata;
                    tklsb_d = 1'b0;
                end
            end
            ST_CHK: begin
                txd_d   = csum;
                tklsb_d = 1'b0;
                busy_d  = 1'b1;
            end
            ST_EOF: begin
                txd_d  = K_EOF;
                busy_d = 1'b1;
                err_d  = oversize;
            end
            default: ;
        endcase
    end

    // Frame datapath: payload counter, checksum, truncation flag, gap counter, sequence.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt      <= '0;
            csum     <= '0;
            oversize <= 1'b0;
            gap_cnt  <= '0;
            o_seq    <= '0;
        end else begin
            case (state)
                ST_HDR: begin
                    cnt  <= '0;
                    csum <= '0;
                end
                ST_PAY: begin
                    if (accept) begin
                        cnt  <= cnt + CNT_W'(1);
                        csum <= csum + i_tdata;
                        // A tlast on the MAX_LEN-th word is a clean end, not a truncation.
                        if (!i_tlast && hit_max) oversize <= 1'b1;
                    end
                end
                ST_EOF: begin
                    o_seq    <= o_seq + WORD_W'(1);
                    oversize <= 1'b0;
                    gap_cnt  <= '0;
                end
                ST_GAP:  gap_cnt <= gap_cnt + GAP_W'(1);
                default: ;
            endcase
        end
    end

    // Registered TX bus and status outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_txd          <= K_IDLE;
            o_tklsb        <= 1'b1;
            o_tkmsb        <= 1'b0;
            o_busy         <= 1'b0;
            o_err_oversize <= 1'b0;
        end else begin
            o_txd          <= txd_d;
            o_tklsb        <= tklsb_d;
            o_tkmsb        <= 1'b0;
            o_busy         <= busy_d;
            o_err_oversize <= err_d;
        end
    end

    // Device control pins: enable and reference lock come up one cycle after reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_tlk_enable  <= 1'b0;
            o_tlk_lckrefn <= 1'b0;
            o_tlk_loopen  <= 1'b0;
            o_tlk_prbsen  <= 1'b0;
        end else begin
            o_tlk_enable  <= 1'b1;
            o_tlk_lckrefn <= 1'b1;
            o_tlk_loopen  <= i_loopen;
            o_tlk_prbsen  <= i_prbsen;
        end
    end

endmodule

// File: tb/tb_tlk2711_tx_framer.sv
// Self-checking bench for tlk2711_tx_framer (MAX_LEN=4, IFG_WORDS=4).
// Expected TX words are queued when a frame is driven and popped by a
// negedge monitor that also checks idle-run lengths, busy and oversize.
module tb_tlk2711_tx_framer;

    localparam int unsigned MAXL = 4;
    localparam int unsigned IFG  = 4;
    localparam logic [15:0] W_IDLE = 16'hC5BC;
    localparam logic [15:0] W_SOF  = 16'h50FB;
    localparam logic [15:0] W_EOF  = 16'h50FD;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [15:0] i_tdata = '0;
    logic        i_tvalid = 1'b0;
    logic        i_tlast = 1'b0;
    logic        o_tready;
    logic        i_loopen = 1'b0;
    logic        i_prbsen = 1'b0;
    logic [15:0] o_txd;
    logic        o_tkmsb;
    logic        o_tklsb;
    logic        o_tlk_enable;
    logic        o_tlk_lckrefn;
    logic        o_tlk_loopen;
    logic        o_tlk_prbsen;
    logic [15:0] o_seq;
    logic        o_busy;
    logic        o_err_oversize;

    typedef struct {
        logic [15:0] txd;
        logic        k;
        logic        err;
        int          idles;   // idle words expected just before this word, -1 = don't care
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] seq_m = '0;
    logic [15:0] frame_w[16];
    int          frame_g[16];

    always #5 i_clk = ~i_clk;

    tlk2711_tx_framer #(.MAX_LEN(MAXL), .IFG_WORDS(IFG)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tlast(i_tlast), .o_tready(o_tready),
        .i_loopen(i_loopen), .i_prbsen(i_prbsen),
        .o_txd(o_txd), .o_tkmsb(o_tkmsb), .o_tklsb(o_tklsb),
        .o_tlk_enable(o_tlk_enable), .o_tlk_lckrefn(o_tlk_lckrefn),
        .o_tlk_loopen(o_tlk_loopen), .o_tlk_prbsen(o_tlk_prbsen),
        .o_seq(o_seq), .o_busy(o_busy), .o_err_oversize(o_err_oversize)
    );

    task automatic push(input logic [15:0] t, input logic k, input logic e, input int idl);
        exp_t x;
        x.txd = t; x.k = k; x.err = e; x.idles = idl;
        exp_q.push_back(x);
    endtask

    task automatic monitor();
        int   idle_run = 1000;
        logic in_frame = 1'b0;
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                idle_run = 1000;
                in_frame = 1'b0;
            end else begin
                checks++;
                if (o_tkmsb !== 1'b0) begin
                    errors++; $display("FAIL mon_tkmsb: got %b expected 0", o_tkmsb);
                end
                if (o_txd === W_IDLE && o_tklsb === 1'b1) begin
                    checks++;
                    if (o_err_oversize !== 1'b0) begin
                        errors++; $display("FAIL mon_err_idle: got %b expected 0", o_err_oversize);
                    end
                    checks++;
                    if (o_busy !== in_frame) begin
                        errors++; $display("FAIL mon_busy_idle: got %b expected %b", o_busy, in_frame);
                    end
                    idle_run++;
                end else if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mon_unexpected: got %h k%b expected idle", o_txd, o_tklsb);
                    idle_run = 0;
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if (o_txd !== e.txd || o_tklsb !== e.k || o_err_oversize !== e.err || o_busy !== 1'b1) begin
                        errors++;
                        $display("FAIL mon_word: got %h k%b err%b busy%b expected %h k%b err%b busy1",
                                 o_txd, o_tklsb, o_err_oversize, o_busy, e.txd, e.k, e.err);
                    end
                    if (e.idles >= 0) begin
                        checks++;
                        if (idle_run != e.idles) begin
                            errors++;
                            $display("FAIL mon_idles before %h: got %0d expected %0d", e.txd, idle_run, e.idles);
                        end
                    end
                    if (e.k && e.txd == W_SOF) in_frame = 1'b1;
                    if (e.k && e.txd == W_EOF) in_frame = 1'b0;
                    idle_run = 0;
                end
            end
        end
    endtask

    // Present one word and hold it until accepted; returns at posedge+1.
    task automatic drive_word(input logic [15:0] d, input logic last);
        int n = 0;
        i_tdata = d; i_tlast = last; i_tvalid = 1'b1;
        @(negedge i_clk);
        while (o_tready !== 1'b1 && n < 200) begin
            n++;
            @(negedge i_clk);
        end
        if (o_tready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL drive_timeout: tready got %b expected 1 within 200 cycles", o_tready);
        end
        @(posedge i_clk); #1;
        i_tvalid = 1'b0; i_tlast = 1'b0;
    endtask

    task automatic clear_frame();
        for (int i = 0; i < 16; i++) begin
            frame_w[i] = '0;
            frame_g[i] = 0;
        end
    endtask

    // Queue the expected frame (model of truncation and checksum) then drive it.
    task automatic send_frame(input int n, input int sof_idles);
        logic [15:0] csum;
        int          kept;
        logic        trunc;
        csum  = '0;
        kept  = (n > int'(MAXL)) ? int'(MAXL) : n;
        trunc = (n > int'(MAXL));
        push(W_SOF, 1'b1, 1'b0, sof_idles);
        push(seq_m, 1'b0, 1'b0, 0);
        for (int i = 0; i < kept; i++) begin
            csum = csum + frame_w[i];
            push(frame_w[i], 1'b0, 1'b0, (i == 0) ? 0 : frame_g[i]);
        end
        push(csum, 1'b0, 1'b0, 0);
        push(W_EOF, 1'b1, trunc, 0);
        seq_m = seq_m + 16'd1;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                repeat (frame_g[i]) begin
                    @(posedge i_clk); #1;
                end
            end
            drive_word(frame_w[i], (i == n - 1));
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge i_clk);
            n++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d words outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (o_seq !== seq_m) begin
            errors++; $display("FAIL seq: got %h expected %h", o_seq, seq_m);
        end
        repeat (10) @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        logic [24:0] obs;
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        obs = {o_txd, o_tklsb, o_tkmsb, o_tready, o_busy, o_err_oversize,
               o_tlk_enable, o_tlk_lckrefn, o_tlk_loopen, o_tlk_prbsen};
        checks++;
        if (obs !== {W_IDLE, 9'b1_0000_0000}) begin
            errors++; $display("FAIL reset_outputs: got %h expected %h", obs, {W_IDLE, 9'b1_0000_0000});
        end
        checks++;
        if (o_seq !== 16'h0000) begin
            errors++; $display("FAIL reset_seq: got %h expected 0000", o_seq);
        end
        i_rst = 1'b0;
        #1;
        checks++;
        if ({o_tlk_enable, o_tlk_lckrefn} !== 2'b00) begin
            errors++; $display("FAIL reset_ctrl_early: got %b expected 00", {o_tlk_enable, o_tlk_lckrefn});
        end
        @(posedge i_clk); #1;
        checks++;
        if ({o_tlk_enable, o_tlk_lckrefn} !== 2'b11) begin
            errors++; $display("FAIL reset_ctrl_up: got %b expected 11", {o_tlk_enable, o_tlk_lckrefn});
        end
        seq_m = '0;
    endtask

    task automatic test_ctrl();
        i_loopen = 1'b1; i_prbsen = 1'b0;
        #1;
        checks++;
        if (o_tlk_loopen !== 1'b0) begin
            errors++; $display("FAIL loopen_latency: got %b expected 0", o_tlk_loopen);
        end
        @(posedge i_clk); #1;
        checks++;
        if ({o_tlk_loopen, o_tlk_prbsen} !== 2'b10) begin
            errors++; $display("FAIL loopen_set: got %b expected 10", {o_tlk_loopen, o_tlk_prbsen});
        end
        i_loopen = 1'b0; i_prbsen = 1'b1;
        @(posedge i_clk); #1;
        checks++;
        if ({o_tlk_loopen, o_tlk_prbsen} !== 2'b01) begin
            errors++; $display("FAIL prbsen_set: got %b expected 01", {o_tlk_loopen, o_tlk_prbsen});
        end
        i_prbsen = 1'b0;
        @(posedge i_clk); #1;
    endtask

    task automatic test_basic();
        clear_frame();
        frame_w[0] = 16'h0001; frame_w[1] = 16'h0002; frame_w[2] = 16'h0003;
        send_frame(3, -1);
        wait_drain();
    endtask

    task automatic test_fill();
        clear_frame();
        frame_w[0] = 16'h0001; frame_w[1] = 16'h0002; frame_w[2] = 16'h0003;
        frame_g[1] = 2;
        send_frame(3, -1);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        clear_frame();
        frame_w[0] = 16'h0010; frame_w[1] = 16'h0020;
        send_frame(2, -1);
        frame_w[0] = 16'h0030;
        send_frame(1, int'(IFG) + 1);
        frame_w[0] = 16'hC5BC; frame_w[1] = 16'h50FB;
        send_frame(2, int'(IFG) + 1);
        wait_drain();
    endtask

    task automatic test_oversize();
        clear_frame();
        for (int i = 0; i < 6; i++) frame_w[i] = 16'(i + 1);
        send_frame(6, -1);
        clear_frame();
        frame_w[0] = 16'h0077;
        // Two dropped words, the inter-frame gap, then one IDLE-state cycle.
        send_frame(1, 2 + int'(IFG) + 1);
        wait_drain();
    endtask

    task automatic test_exact_max();
        clear_frame();
        for (int i = 0; i < 4; i++) frame_w[i] = 16'h0100 + 16'(i);
        send_frame(4, -1);
        clear_frame();
        frame_w[0] = 16'h0055;
        send_frame(1, int'(IFG) + 1);
        wait_drain();
    endtask

    task automatic test_csum_wrap();
        clear_frame();
        frame_w[0] = 16'hFFFF; frame_w[1] = 16'h0002;
        send_frame(2, -1);
        wait_drain();
    endtask

    task automatic test_random();
        int n;
        for (int f = 0; f < 20; f++) begin
            clear_frame();
            n = int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++) begin
                frame_w[i] = 16'($urandom);
                frame_g[i] = int'($urandom_range(0, 2));
            end
            send_frame(n, -1);
        end
        wait_drain();
    endtask

    task automatic test_reset_mid_frame();
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        seq_m = '0;
        @(posedge i_clk); #1;
        clear_frame();
        for (int f = 0; f < 5; f++) begin
            frame_w[0] = 16'(f + 16'h0200);
            send_frame(1, -1);
        end
        wait_drain();
        push(W_SOF, 1'b1, 1'b0, -1);
        push(seq_m, 1'b0, 1'b0, 0);
        push(16'h1234, 1'b0, 1'b0, 0);
        drive_word(16'h1234, 1'b0);
        wait_drain();
        checks++;
        if ({o_tready, o_busy} !== 2'b11) begin
            errors++; $display("FAIL mid_pay_state: got %b expected 11", {o_tready, o_busy});
        end
        #1;
        i_rst = 1'b1;
        #1;
        checks++;
        if ({o_txd, o_tklsb, o_tready, o_busy} !== {W_IDLE, 3'b100}) begin
            errors++;
            $display("FAIL mid_reset_out: got %h expected %h", {o_txd, o_tklsb, o_tready, o_busy}, {W_IDLE, 3'b100});
        end
        checks++;
        if (o_seq !== 16'h0000) begin
            errors++; $display("FAIL mid_reset_seq: got %h expected 0000", o_seq);
        end
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        seq_m = '0;
        clear_frame();
        frame_w[0] = 16'hABCD;
        send_frame(1, -1);
        wait_drain();
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_ctrl();
        test_basic();
        test_fill();
        test_back_to_back();
        test_oversize();
        test_exact_max();
        test_csum_wrap();
        test_random();
        test_reset_mid_frame();
        repeat (5) @(posedge i_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
